// File: rtl/ramrw_ctl_pkg.sv
// Shared definitions for the RAM read/write controller.
// Holds the controller state encoding and the collision counter width.
package ramrw_ctl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam int COLL_CNT_W = 16;
  localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = '1;

endpackage

// File: rtl/ramrw_ctl_clr.sv
// Clear sequencer for the RAM controller.
// While start_i is held high it steps addr_o from 0 to DEPTH-1, one word per
// cycle, and pulses done_o on the last word; the counter then returns to 0
// so the next clear begins at address 0 again.
module ramrw_ctl_clr
  import ramrw_ctl_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDRBIT-1:0] addr_o
);

  localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

  logic [ADDRBIT-1:0] addr_q;
  logic [ADDRBIT-1:0] addr_d;

  // Advance the clear address while enabled and wrap to 0 after the last word.
  always_comb begin
    busy_o = start_i;
    done_o = start_i && (addr_q == LAST_ADDR);
    addr_d = addr_q;
    if (done_o) begin
      addr_d = '0;
    end else if (start_i) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Clear address register; an async reset restarts any clear from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ramrw_ctl.sv
// RAM read/write controller: clears the RAM after reset or on request, then
// arbitrates a write channel and a read channel onto a single-clock RAM with
// separate write and read ports. Writes win over reads to the same address.
// Optional feature: define RAMRW_CTL_BYPASS_EN to return the colliding write
// data directly to the reader instead of stalling the read for one cycle.
module ramrw_ctl
  import ramrw_ctl_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [ADDRBIT-1:0]    wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_vld,
  output logic                  rd_rdy,
  input  logic [ADDRBIT-1:0]    rd_addr,
  output logic                  rd_dvld,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  ram_we,
  output logic [ADDRBIT-1:0]    ram_wa,
  output logic [WIDTH-1:0]      ram_di,
  output logic                  ram_re,
  output logic [ADDRBIT-1:0]    ram_ra,
  input  logic [WIDTH-1:0]      ram_do,
  output logic                  ram_test,
  output logic                  ram_mask,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  state_e state_q;
  state_e state_d;

  logic               clrBusy;
  logic               clrDone;
  logic [ADDRBIT-1:0] clrAddr;

  logic runOk;
  logic coll;
  logic wrAcc;
  logic rdAcc;

  logic [ADDRBIT-1:0]    raHold_q;
  logic [ADDRBIT-1:0]    raHold_d;
  logic                  rdVld_q;
  logic [WIDTH-1:0]      rdHold_q;
  logic [COLL_CNT_W-1:0] collCnt_q;
  logic [COLL_CNT_W-1:0] collCnt_d;

`ifdef RAMRW_CTL_BYPASS_EN
  logic             bypVld_q;
  logic [WIDTH-1:0] bypData_q;
`endif

  ramrw_ctl_clr #(
    .ADDRBIT (ADDRBIT),
    .DEPTH   (DEPTH)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (state_q == S_INIT),
    .busy_o  (clrBusy),
    .done_o  (clrDone),
    .addr_o  (clrAddr)
  );

  // Controller state: reset -> clear -> run, and back to clear on request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_INIT;
      S_INIT:  if (clrDone) state_d = S_RUN;
      S_RUN:   if (init_req) state_d = S_INIT;
      default: state_d = S_RST;
    endcase
  end

  // Handshakes, RAM port drive and read data selection.
  always_comb begin
    runOk     = (state_q == S_RUN) && !init_req;
    coll      = runOk && wr_vld && rd_vld && (wr_addr == rd_addr);
    wrAcc     = runOk && wr_vld;
    wr_rdy    = runOk;
    init_busy = (state_q == S_RST) || clrBusy;

`ifdef RAMRW_CTL_BYPASS_EN
    rd_rdy = runOk;
    rdAcc  = rd_vld && rd_rdy;
    ram_re = rdAcc && !coll;
`else
    rd_rdy = runOk && !coll;
    rdAcc  = rd_vld && rd_rdy;
    ram_re = rdAcc;
`endif

    ram_we = 1'b0;
    ram_wa = '0;
    ram_di = '0;
    if (state_q == S_INIT) begin
      ram_we = 1'b1;
      ram_wa = clrAddr;
    end else if (wrAcc) begin
      ram_we = 1'b1;
      ram_wa = wr_addr;
      ram_di = wr_data;
    end

    ram_ra   = ram_re ? rd_addr : raHold_q;
    raHold_d = ram_ra;

    rd_data = rdHold_q;
    if (rdVld_q) begin
`ifdef RAMRW_CTL_BYPASS_EN
      rd_data = bypVld_q ? bypData_q : ram_do;
`else
      rd_data = ram_do;
`endif
    end

    collCnt_d = collCnt_q;
    if ((state_d == S_INIT) && (state_q != S_INIT)) begin
      collCnt_d = '0;
    end else if (coll && (collCnt_q != COLL_CNT_MAX)) begin
      collCnt_d = collCnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Read pipeline, held read address/data and the saturating collision count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raHold_q  <= '0;
      rdVld_q   <= 1'b0;
      rdHold_q  <= '0;
      collCnt_q <= '0;
    end else begin
      raHold_q  <= raHold_d;
      rdVld_q   <= rdAcc;
      rdHold_q  <= rd_data;
      collCnt_q <= collCnt_d;
    end
  end

`ifdef RAMRW_CTL_BYPASS_EN
  // Capture colliding write data so it can be returned in place of RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypVld_q  <= 1'b0;
      bypData_q <= '0;
    end else begin
      bypVld_q <= coll;
      if (coll) begin
        bypData_q <= wr_data;
      end
    end
  end
`endif

  assign rd_dvld  = rdVld_q;
  assign ram_test = 1'b0;
  assign ram_mask = 1'b0;
  assign coll_cnt = collCnt_q;

endmodule

// File: tb/tb_ramrw_ctl.sv
// Self-checking bench for ramrw_ctl with a behavioural RAM, a shadow memory
// model and a read-data scoreboard. Works with or without RAMRW_CTL_BYPASS_EN.
module tb_ramrw_ctl;

`ifdef RAMRW_CTL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        init_req;
  logic        init_busy;
  logic        wr_vld;
  logic        wr_rdy;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_vld;
  logic        rd_rdy;
  logic [8:0]  rd_addr;
  logic        rd_dvld;
  logic [31:0] rd_data;
  logic        ram_we;
  logic [8:0]  ram_wa;
  logic [31:0] ram_di;
  logic        ram_re;
  logic [8:0]  ram_ra;
  logic [31:0] ram_do;
  logic        ram_test;
  logic        ram_mask;
  logic [15:0] coll_cnt;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] mem   [0:511];
  logic [31:0] model [0:511];
  int          cyc;
  int          checkCount;
  int          errorCount;

  ramrw_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_busy (init_busy),
    .wr_vld    (wr_vld),
    .wr_rdy    (wr_rdy),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_vld    (rd_vld),
    .rd_rdy    (rd_rdy),
    .rd_addr   (rd_addr),
    .rd_dvld   (rd_dvld),
    .rd_data   (rd_data),
    .ram_we    (ram_we),
    .ram_wa    (ram_wa),
    .ram_di    (ram_di),
    .ram_re    (ram_re),
    .ram_ra    (ram_ra),
    .ram_do    (ram_do),
    .ram_test  (ram_test),
    .ram_mask  (ram_mask),
    .coll_cnt  (coll_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-clock RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_do <= mem[ram_ra];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [8:0] wa, input logic [31:0] wd,
                               input logic rv, input logic [8:0] ra, input logic ir);
    @(posedge clk);
    #1;
    wr_vld   = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_vld   = rv;
    rd_addr  = ra;
    init_req = ir;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b0);
  endtask

  // Counts busy cycles and checks the clear sweep 0..511 with zero data.
  task automatic waitInit(input string tag, input int expBusy);
    int n;
    int idx;
    int bad;
    n = 0;
    idx = 0;
    bad = 0;
    @(negedge clk);
    while (init_busy && n < 3000) begin
      n++;
      if (ram_we) begin
        if (ram_wa !== 9'(idx) || ram_di !== 32'h0) bad++;
        idx++;
      end
      @(negedge clk);
    end
    checkOutput({tag, "BusyCycles"}, n, expBusy);
    checkOutput({tag, "ClrWrites"}, idx, 512);
    checkOutput({tag, "ClrSeq"}, bad, 0);
    checkOutput({tag, "WrRdyAfter"}, wr_rdy, 1);
    checkOutput({tag, "RdRdyAfter"}, rd_rdy, 1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("drainTimeout", sbQ.size(), 0);
  endtask

  // Observer: tracks accepted writes/reads in the shadow model and scores read data.
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbQ.delete();
      end else begin
        if (init_busy) begin
          for (int i = 0; i < 512; i++) model[i] = 32'h0;
        end
        if (rd_dvld) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedDvld", 1, 0);
          end else begin
            e = sbQ.pop_front();
            checkOutput("rdData", rd_data, e.data);
            checkOutput("rdLatency", cyc - e.cyc, 1);
          end
        end
        if (wr_vld && wr_rdy) model[wr_addr] = wr_data;
        if (rd_vld && rd_rdy) sbQ.push_back('{model[rd_addr], cyc});
        if (ram_we && ram_re) checkOutput("weReSameAddr", {31'b0, ram_wa == ram_ra}, 0);
      end
    end
  end

  initial begin
    logic [8:0]  addrs [8];
    logic [31:0] datas [8];
    bit          found;
    checkCount = 0;
    errorCount = 0;
    rst_n    = 1'b0;
    init_req = 1'b0;
    wr_vld   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_vld   = 1'b0;
    rd_addr  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstInitBusy", init_busy, 1);
    checkOutput("rstWrRdy", wr_rdy, 0);
    checkOutput("rstRdRdy", rd_rdy, 0);
    checkOutput("rstRamWe", ram_we, 0);
    checkOutput("rstRamRe", ram_re, 0);
    checkOutput("rstRamWa", ram_wa, 0);
    checkOutput("rstRamDi", ram_di, 0);
    checkOutput("rstRamRa", ram_ra, 0);
    checkOutput("rstRdDvld", rd_dvld, 0);
    checkOutput("rstRdData", rd_data, 0);
    checkOutput("rstCollCnt", coll_cnt, 0);
    checkOutput("ramTest", ram_test, 0);
    checkOutput("ramMask", ram_mask, 0);

    // Release reset: 1 reset cycle + 512 clear cycles
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitInit("init", 513);

    // Write then read the same address in the next cycle
    applyStimulus(1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 9'h0, 1'b0);
    @(negedge clk);
    checkOutput("wrPassWe", ram_we, 1);
    checkOutput("wrPassWa", ram_wa, 9'h010);
    checkOutput("wrPassDi", ram_di, 32'hDEADBEEF);
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, 9'h010, 1'b0);
    @(negedge clk);
    checkOutput("rdPassRe", ram_re, 1);
    checkOutput("rdPassRa", ram_ra, 9'h010);
    idle();
    waitDrain();
    idle();
    @(negedge clk);
    checkOutput("rdDataHold", rd_data, 32'hDEADBEEF);
    checkOutput("rdDvldIdle", rd_dvld, 0);
    checkOutput("ramRaHold", ram_ra, 9'h010);

    // Simultaneous write and read to different addresses
    applyStimulus(1'b1, 9'h020, 32'hA5A5_0001, 1'b1, 9'h010, 1'b0);
    @(negedge clk);
    checkOutput("diffAddrRdRdy", rd_rdy, 1);
    checkOutput("diffAddrRe", ram_re, 1);

    // Random write burst, then read back
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 9'h100 + 9'(i * 17);
      datas[i] = $urandom;
      applyStimulus(1'b1, addrs[i], datas[i], 1'b0, 9'h0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, addrs[7 - i], 1'b0);
    end
    idle();
    waitDrain();

    // Collision at 0x055
    applyStimulus(1'b1, 9'h055, 32'h12345678, 1'b1, 9'h055, 1'b0);
    @(negedge clk);
    checkOutput("collRdRdy", rd_rdy, BYP ? 1 : 0);
    checkOutput("collRamRe", ram_re, 0);
    checkOutput("collRamWe", ram_we, 1);
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, 9'h055, 1'b0);
    @(negedge clk);
    checkOutput("retryRdRdy", rd_rdy, 1);
    checkOutput("retryRamRe", ram_re, 1);
    idle();
    waitDrain();
    checkOutput("collCntOne", coll_cnt, 1);

    // Re-init request with a read in flight
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, 9'h010, 1'b0);
    applyStimulus(1'b1, 9'h011, 32'h1, 1'b1, 9'h012, 1'b1);
    @(negedge clk);
    checkOutput("initReqWrRdy", wr_rdy, 0);
    checkOutput("initReqRdRdy", rd_rdy, 0);
    idle();
    waitInit("reinit", 512);
    checkOutput("reinitCollCnt", coll_cnt, 0);
    checkOutput("reinitQueue", sbQ.size(), 0);
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, 9'h010, 1'b0);
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b1, 9'h055, 1'b0);
    idle();
    waitDrain();

    // Collision counter: partial count, then saturation
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 9'h020, 32'(i), 1'b1, 9'h020, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("collCnt100", coll_cnt, 100);
    for (int i = 100; i < 70000; i++) applyStimulus(1'b1, 9'h020, 32'(i), 1'b1, 9'h020, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("collCntSat", coll_cnt, 16'hFFFF);
    waitDrain();

    // Reset during clear at address 200 restarts the sweep from 0
    applyStimulus(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b1);
    idle();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ram_we && ram_wa == 9'd200) found = 1'b1;
    end
    checkOutput("reachAddr200", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstRamWe", ram_we, 0);
    checkOutput("midRstRamWa", ram_wa, 0);
    checkOutput("midRstBusy", init_busy, 1);
    checkOutput("midRstCollCnt", coll_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitInit("restart", 513);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
